// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - SM4 key-expansion constants, FSM state type and the L' key transform
package sm4_pkg;

  localparam int N_ROUNDS = 32;
  localparam int CNT_W    = 5;

  localparam logic [31:0] FK0 = 32'ha3b1bac6;
  localparam logic [31:0] FK1 = 32'h56aa3350;
  localparam logic [31:0] FK2 = 32'h677d9197;
  localparam logic [31:0] FK3 = 32'hb27022dc;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ROUND = 2'd2
  } state_t;

  // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

endpackage

// File: rtl/sm4_key_expand_sbox.sv
// rtl/sm4_key_expand_sbox.sv - combinational SM4 8-bit S-box lookup
module sm4_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign o_out = SBOX[i_in];

endmodule

// File: rtl/sm4_key_expand.sv
// rtl/sm4_key_expand.sv - SM4 round-key generator, one rk per cycle; optional key store under SM4_RK_STORE_EN
module sm4_key_expand
  import sm4_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [127:0]     i_key,
  output logic [CNT_W-1:0] o_ck_count,
  input  logic [31:0]      i_ck_i,
  output logic             o_busy,
  output logic             o_rk_valid,
  output logic [4:0]       o_rk_idx,
  output logic [31:0]      o_rk,
  output logic             o_done
`ifdef SM4_RK_STORE_EN
  ,
  input  logic [4:0]       i_rd_idx,
  input  logic             i_rd_dec,
  output logic [31:0]      o_rd_rk
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      r_k0, r_k1, r_k2, r_k3;
  logic [4:0]       r_round;
  logic [CNT_W-1:0] r_ck_count;
  logic             r_busy, r_rk_valid, r_done;
  logic [4:0]       r_rk_idx;
  logic [31:0]      r_rk;
  logic [31:0]      w_x, w_tau, w_rk_new;

  // Round function input: the CK word arrives registered, one cycle after its index.
  assign w_x      = r_k1 ^ r_k2 ^ r_k3 ^ i_ck_i;
  assign w_rk_new = r_k0 ^ l_key(w_tau);

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_tau
      sm4_sbox u_sbox (
        .i_in  (w_x[8*g +: 8]),
        .o_out (w_tau[8*g +: 8])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; busy still covers the rk31 cycle, so it also gates start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_round == 5'(N_ROUNDS - 1));
    case (r_state)
      IDLE: begin
        w_accept = i_start && !r_busy;
        if (w_accept) w_state_nxt = PRIME;
      end
      PRIME:   w_state_nxt = ROUND;
      ROUND:   if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Key schedule datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k0       <= '0;
      r_k1       <= '0;
      r_k2       <= '0;
      r_k3       <= '0;
      r_round    <= '0;
      r_ck_count <= '0;
      r_busy     <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_rk_idx   <= '0;
      r_rk       <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_k0       <= i_key[127:96] ^ FK0;
            r_k1       <= i_key[95:64]  ^ FK1;
            r_k2       <= i_key[63:32]  ^ FK2;
            r_k3       <= i_key[31:0]   ^ FK3;
            r_ck_count <= '0;
            r_busy     <= 1'b1;
          end
        end
        PRIME: begin
          r_ck_count <= CNT_W'(1);
          r_round    <= '0;
        end
        ROUND: begin
          r_rk       <= w_rk_new;
          r_rk_idx   <= r_round;
          r_rk_valid <= 1'b1;
          r_k0       <= r_k1;
          r_k1       <= r_k2;
          r_k2       <= r_k3;
          r_k3       <= w_rk_new;
          r_ck_count <= r_round + CNT_W'(2);
          r_round    <= r_round + 5'd1;
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ck_count = r_ck_count;
  assign o_busy     = r_busy;
  assign o_rk_valid = r_rk_valid;
  assign o_rk_idx   = r_rk_idx;
  assign o_rk       = r_rk;
  assign o_done     = r_done;

`ifdef SM4_RK_STORE_EN
  logic [31:0] r_store [32];
  logic [31:0] r_rd_rk;

  // Capture each emitted round key; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (r_rk_valid) r_store[r_rk_idx] <= r_rk;
  end

  // Registered read; decrypt order is 31 - rd_idx, i.e. the bitwise complement.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_rk <= '0;
    else       r_rd_rk <= r_store[i_rd_dec ? ~i_rd_idx : i_rd_idx];
  end

  assign o_rd_rk = r_rd_rk;
`endif

endmodule

// File: tb/tb_sm4_key_expand.sv
// tb/tb_sm4_key_expand.sv - self-checking bench for sm4_key_expand with CK generator and SM4 reference model
module tb_sm4_key_expand;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [127:0] i_key;
  logic [4:0]   o_ck_count;
  logic [31:0]  i_ck_i;
  logic         o_busy, o_rk_valid, o_done;
  logic [4:0]   o_rk_idx;
  logic [31:0]  o_rk;
`ifdef SM4_RK_STORE_EN
  logic [4:0]   i_rd_idx;
  logic         i_rd_dec;
  logic [31:0]  o_rd_rk;
`endif

  sm4_key_expand dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_key      (i_key),
    .o_ck_count (o_ck_count),
    .i_ck_i     (i_ck_i),
    .o_busy     (o_busy),
    .o_rk_valid (o_rk_valid),
    .o_rk_idx   (o_rk_idx),
    .o_rk       (o_rk),
    .o_done     (o_done)
`ifdef SM4_RK_STORE_EN
    ,
    .i_rd_idx   (i_rd_idx),
    .i_rd_dec   (i_rd_dec),
    .o_rd_rk    (o_rd_rk)
`endif
  );

  always #5 i_clk = ~i_clk;

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  localparam logic [127:0] TK = 128'h0123456789abcdeffedcba9876543210;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_rk [32];
  logic [31:0] got_rk [32];
  int          n_valid, n_busy, first_c;

  // CK_i byte j = (4i+j)*7 mod 256, most significant byte first.
  function automatic logic [31:0] ck_word(input int i);
    logic [7:0] b [4];
    for (int j = 0; j < 4; j++) b[j] = 8'(((4 * i + j) * 7) % 256);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Registered CK generator outside the DUT.
  always @(posedge i_clk) i_ck_i <= ck_word(int'(o_ck_count));

  task automatic ref_expand(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] x, t;
    k[0] = mk[127:96] ^ 32'ha3b1bac6;
    k[1] = mk[95:64]  ^ 32'h56aa3350;
    k[2] = mk[63:32]  ^ 32'h677d9197;
    k[3] = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i);
      t = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
      k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
      exp_rk[i] = k[i+4];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ck_count"}, 32'(o_ck_count), 32'd0);
    chk({tag, "_rk"},       o_rk,            32'd0);
    chk({tag, "_rk_idx"},   32'(o_rk_idx),   32'd0);
    chk({tag, "_busy"},     32'(o_busy),     32'd0);
    chk({tag, "_rk_valid"}, 32'(o_rk_valid), 32'd0);
    chk({tag, "_done"},     32'(o_done),     32'd0);
`ifdef SM4_RK_STORE_EN
    chk({tag, "_rd_rk"},    o_rd_rk,         32'd0);
`endif
  endtask

  // mode 0: plain run; 1: second start at rk_idx 10; 2: reset at rk_idx 5; 3: start during rk31 cycle
  task automatic run(input logic [127:0] key, input int mode, input string tag);
    bit aborted = 0;
    ref_expand(key);
    n_valid = 0; n_busy = 0; first_c = -1;
    @(negedge i_clk);
    i_key = key; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_key = ~key;
    for (int c = 1; c <= 40; c++) begin
      if (o_busy) n_busy++;
      if (c <= 32) chk({tag, "_ck_count"}, 32'(o_ck_count), 32'(c - 1));
      if (o_rk_valid) begin
        if (first_c < 0) first_c = c;
        if (n_valid < 32) begin
          chk({tag, "_rk_idx"}, 32'(o_rk_idx), 32'(n_valid));
          chk({tag, "_rk"}, o_rk, exp_rk[n_valid]);
          chk({tag, "_done"}, 32'(o_done), 32'(n_valid == 31));
          got_rk[n_valid] = o_rk;
        end
        n_valid++;
      end else begin
        chk({tag, "_done_idle"}, 32'(o_done), 32'd0);
      end
      i_start = 1'b0;
      if (mode == 1 && o_rk_valid && o_rk_idx == 5'd10) begin
        i_start = 1'b1; i_key = key ^ 128'h1;
      end
      if (mode == 3 && o_rk_valid && o_rk_idx == 5'd31) i_start = 1'b1;
      if (mode == 2 && o_rk_valid && o_rk_idx == 5'd5) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        chk_all_zero({tag, "_abort"});
        i_rst = 1'b0;
        aborted = 1;
        break;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    if (!aborted) begin
      chk({tag, "_n_valid"}, 32'(n_valid), 32'd32);
      chk({tag, "_n_busy"},  32'(n_busy),  32'd34);
      chk({tag, "_first"},   32'(first_c), 32'd3);
      chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_key = '0;
`ifdef SM4_RK_STORE_EN
    i_rd_idx = '0; i_rd_dec = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst = 1'b0;

    run(TK, 0, "t1");
    chk("t1_rk0",  got_rk[0],  32'hf12186f9);
    chk("t1_rk1",  got_rk[1],  32'h41662b61);
    chk("t1_rk31", got_rk[31], 32'h9124a012);

`ifdef SM4_RK_STORE_EN
    i_rd_idx = 5'd0; i_rd_dec = 1'b1;
    @(negedge i_clk);
    chk("t6_dec0", o_rd_rk, 32'h9124a012);
    i_rd_dec = 1'b0;
    @(negedge i_clk);
    chk("t6_enc0", o_rd_rk, 32'hf12186f9);
    for (int i = 0; i < 6; i++) begin
      int idx;
      int dec;
      idx = int'($urandom_range(0, 31));
      dec = int'($urandom_range(0, 1));
      i_rd_idx = 5'(idx); i_rd_dec = dec[0];
      @(negedge i_clk);
      chk("t6_rand", o_rd_rk, exp_rk[dec != 0 ? 31 - idx : idx]);
    end
`endif

    run(TK, 1, "t3");
    chk("t3_rk31", got_rk[31], 32'h9124a012);

    run(TK, 3, "t_last_start");

    run(TK, 2, "t4");
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      chk("t4_no_valid", 32'(o_rk_valid), 32'd0);
    end
    run(TK, 0, "t4_restart");
    chk("t4_rk0", got_rk[0], 32'hf12186f9);

    run(128'h0, 0, "t5");

    for (int i = 0; i < 3; i++)
      run({$urandom, $urandom, $urandom, $urandom}, 0, "rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
